// File: rtl/mac_pkg.sv
// Shared constants for the time-domain MAC accumulator: defaults, field widths
// and FSM state encodings.
package mac_pkg;

    localparam int unsigned CONV_CYC_DEF = 4;
    localparam int unsigned ACC_W_DEF    = 10;

    localparam int unsigned LEN_W   = 4;
    localparam int unsigned PROD_W  = 8;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] ST_CONV = 2'd1;
    localparam logic [STATE_W-1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/conv_timer.sv
// Per-conversion cycle counter: counts 0..CONV_CYC-1 while enabled and flags
// the last cycle of each conversion with a combinational wrap pulse.
module conv_timer
    import mac_pkg::*;
#(
    parameter int unsigned CONV_CYC = CONV_CYC_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    output logic o_wrap_c
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CONV_CYC - 1);

    logic [CNT_W-1:0] r_count;

    assign o_wrap_c = i_en && (r_count == LAST_CNT);

    // Held at zero while disabled so every CONV entry starts a fresh conversion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (!i_en || o_wrap_c) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mac_accumulator.sv
// Frame accumulator for a time-domain multiply-add front end: launches one
// conversion per product, sums the returned codes with saturation, and holds
// the result under a valid/ready handshake.
module mac_accumulator
    import mac_pkg::*;
#(
    parameter int unsigned CONV_CYC = CONV_CYC_DEF,
    parameter int unsigned ACC_W    = ACC_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic [PROD_W-1:0] prod,
    output logic              conv_strobe,
    output logic              busy,
    output logic [ACC_W-1:0]  acc,
    output logic              sat,
    output logic              acc_valid,
    input  logic              acc_ready
);

    logic [STATE_W-1:0] r_state;
    logic [LEN_W-1:0]   r_rem;
    logic [ACC_W-1:0]   r_acc;
    logic               r_sat;
    logic               r_valid;
    logic               r_strobe;
    logic               r_busy;

    logic [STATE_W-1:0] w_state_nxt;
    logic [LEN_W-1:0]   w_rem_nxt;
    logic [ACC_W-1:0]   w_acc_nxt;
    logic               w_sat_nxt;
    logic               w_valid_nxt;
    logic               w_strobe_nxt;
    logic               w_busy_nxt;
    logic               w_timer_en;
    logic               w_wrap_c;
    logic [ACC_W:0]     w_sum;

    assign w_timer_en = (r_state == ST_CONV);
    assign w_sum      = (ACC_W+1)'(r_acc) + (ACC_W+1)'(prod);

    conv_timer #(
        .CONV_CYC (CONV_CYC)
    ) u_conv_timer (
        .clk      (clk),
        .rst_n    (rst),
        .i_en     (w_timer_en),
        .o_wrap_c (w_wrap_c)
    );

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_rem    <= '0;
            r_acc    <= '0;
            r_sat    <= 1'b0;
            r_valid  <= 1'b0;
            r_strobe <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_rem    <= w_rem_nxt;
            r_acc    <= w_acc_nxt;
            r_sat    <= w_sat_nxt;
            r_valid  <= w_valid_nxt;
            r_strobe <= w_strobe_nxt;
            r_busy   <= w_busy_nxt;
        end
    end

    // Next-state logic; the strobe is registered one cycle early so it lands on counter=0
    always_comb begin
        w_state_nxt  = r_state;
        w_rem_nxt    = r_rem;
        w_acc_nxt    = r_acc;
        w_sat_nxt    = r_sat;
        w_strobe_nxt = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_rem_nxt = len;
                    w_acc_nxt = '0;
                    w_sat_nxt = 1'b0;
                    if (len == '0) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt  = ST_CONV;
                        w_strobe_nxt = 1'b1;
                    end
                end
            end
            ST_CONV: begin
                if (w_wrap_c) begin
                    if (w_sum[ACC_W]) begin
                        w_acc_nxt = '1;
                        w_sat_nxt = 1'b1;
                    end else begin
                        w_acc_nxt = w_sum[ACC_W-1:0];
                    end
                    w_rem_nxt = r_rem - LEN_W'(1);
                    if (r_rem == LEN_W'(1)) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_strobe_nxt = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (acc_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_valid_nxt = (w_state_nxt == ST_DONE);
        w_busy_nxt  = (w_state_nxt != ST_IDLE);
    end

    assign conv_strobe = r_strobe;
    assign busy        = r_busy;
    assign acc         = r_acc;
    assign sat         = r_sat;
    assign acc_valid   = r_valid;

endmodule

// File: tb/tb_mac_accumulator.sv
// Scoreboard bench for mac_accumulator: stimulus queues expected frame results,
// a negedge monitor checks results, strobe spacing and handshake behaviour.
module tb_mac_accumulator;

    localparam int CC = 4;

    typedef struct {
        logic [9:0] acc;
        logic       sat;
        int         cyc;
        int         strobes;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] len;
    logic [7:0] prod;
    logic       conv_strobe;
    logic       busy;
    logic [9:0] acc;
    logic       sat;
    logic       acc_valid;
    logic       acc_ready;

    int         n_chk = 0;
    int         n_err = 0;
    int         cyc = 0;
    exp_t       exp_q[$];
    logic [7:0] prod_q[$];

    int         strb_cnt = 0;
    int         last_strb = 0;
    logic       prev_valid = 1'b0;
    logic [9:0] held_acc = '0;
    logic       held_sat = 1'b0;

    mac_accumulator #(
        .CONV_CYC (CC),
        .ACC_W    (10)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .len         (len),
        .prod        (prod),
        .conv_strobe (conv_strobe),
        .busy        (busy),
        .acc         (acc),
        .sat         (sat),
        .acc_valid   (acc_valid),
        .acc_ready   (acc_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Upstream model and result monitor
    always @(negedge clk) begin
        if (!rst) begin
            strb_cnt   = 0;
            prev_valid = 1'b0;
        end else begin
            if (conv_strobe) begin
                if (strb_cnt > 0) chk("strobe_spacing", cyc - last_strb, CC);
                strb_cnt++;
                last_strb = cyc;
                prod = (prod_q.size() > 0) ? prod_q.pop_front() : 8'd0;
            end
            if (acc_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 0, 1);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("acc", acc, e.acc);
                    chk("sat", sat, e.sat);
                    chk("valid_latency", cyc, e.cyc);
                    chk("strobe_count", strb_cnt, e.strobes);
                    chk("busy_in_done", busy, 1);
                end
                held_acc = acc;
                held_sat = sat;
                strb_cnt = 0;
            end else if (acc_valid && prev_valid) begin
                chk("acc_stable", acc, held_acc);
                chk("sat_stable", sat, held_sat);
            end else if (!acc_valid && prev_valid) begin
                chk("busy_after_accept", busy, 0);
                chk("acc_retained", acc, held_acc);
            end
            prev_valid = acc_valid;
        end
    end

    // Runs one frame starting at the current (post-negedge) time
    task automatic frame(input logic [3:0] n, input logic [9:0] e_acc, input logic e_sat,
                         input int hold, input bit poke_start);
        exp_t e;
        len   = n;
        start = 1'b1;
        @(posedge clk);
        #1;
        e.acc = e_acc;
        e.sat = e_sat;
        e.cyc = cyc + int'(n) * CC;
        e.strobes = int'(n);
        exp_q.push_back(e);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        if (poke_start) begin
            @(negedge clk);
            @(negedge clk);
            start = 1'b1;
            len   = 4'd7;
            @(negedge clk);
            start = 1'b0;
        end
        for (int i = 0; i < 400 && !acc_valid; i++) @(negedge clk);
        if (!acc_valid) chk("valid_timeout", 0, 1);
        repeat (hold) @(negedge clk);
        acc_ready = 1'b1;
        if (poke_start) begin
            start = 1'b1;
            len   = 4'd3;
        end
        @(negedge clk);
        acc_ready = 1'b0;
        start     = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst       = 1'b0;
        start     = 1'b0;
        len       = '0;
        prod      = '0;
        acc_ready = 1'b0;
        #12;
        chk("rst_acc", acc, 0);
        chk("rst_sat", sat, 0);
        chk("rst_valid", acc_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_strobe", conv_strobe, 0);
        @(negedge clk);
        rst = 1'b1;

        prod_q = '{8'd10, 8'd20, 8'd30};
        frame(4'd3, 10'd60, 1'b0, 0, 1'b0);

        prod_q = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255};
        frame(4'd5, 10'd1023, 1'b1, 7, 1'b0);

        prod_q = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd3};
        frame(4'd5, 10'd1023, 1'b0, 1, 1'b0);

        prod_q = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd0};
        frame(4'd6, 10'd1023, 1'b1, 0, 1'b0);

        frame(4'd0, 10'd0, 1'b0, 2, 1'b0);

        prod_q = '{};
        for (int i = 0; i < 15; i++) prod_q.push_back(8'd1);
        frame(4'd15, 10'd15, 1'b0, 0, 1'b0);

        // Abort a len=4 frame during its second conversion
        prod_q = '{8'd1, 8'd2, 8'd3, 8'd4};
        len    = 4'd4;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) @(negedge clk);
        chk("pre_reset_acc", acc, 1);
        #1;
        rst = 1'b0;
        #1;
        chk("midrst_acc", acc, 0);
        chk("midrst_sat", sat, 0);
        chk("midrst_valid", acc_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_strobe", conv_strobe, 0);
        prod_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        prod_q = '{8'd1, 8'd2, 8'd3, 8'd4};
        frame(4'd4, 10'd10, 1'b0, 0, 1'b0);

        prod_q = '{8'd5, 8'd6};
        frame(4'd2, 10'd11, 1'b0, 3, 1'b1);
        repeat (10) @(negedge clk);
        chk("no_restart_busy", busy, 0);
        chk("no_restart_acc", acc, 11);
        chk("no_restart_valid", acc_valid, 0);
        chk("pending_results", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", n_err, n_chk);
        $fatal(1);
    end

endmodule

// File: doc/mac_accumulator.md
MAC_ACCUMULATOR -- requirements
Module: mac_accumulator

Interface
REQ-001 SHALL have parameter CONV_CYC, default 4, giving clock cycles per time-domain multiply-add conversion, with a legal range of 2..15.
REQ-002 SHALL have parameter ACC_W, default 10, giving the accumulator width in bits, with a legal range of 9..16.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port start, input, 1 bit: request to begin one accumulation frame.
REQ-006 SHALL have port len, input, 4 bits: number of products in the frame, sampled with start.
REQ-007 SHALL have port prod, input, 8 bits: product code from the upstream multiply-add TDC output.
REQ-008 SHALL have port conv_strobe, output, 1 bit: one-cycle pulse launching each upstream conversion.
REQ-009 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-010 SHALL have port acc, output, ACC_W bits: the accumulated sum.
REQ-011 SHALL have port sat, output, 1 bit: high when the sum clipped at any point during the frame.
REQ-012 SHALL have port acc_valid, output, 1 bit: high when acc/sat hold the final frame result.
REQ-013 SHALL have port acc_ready, input, 1 bit: downstream accepts the result.

Function
REQ-014 SHALL implement FSM states IDLE, CONV, DONE.
REQ-015 SHALL, in IDLE with start=1, latch len into the remaining-products counter, clear acc and sat, clear the cycle counter, and go to CONV; if len=0 it SHALL go directly to DONE with acc=0 and sat=0.
REQ-016 SHALL ignore start in CONV and DONE, including on the cycle a result is accepted.
REQ-017 SHALL, in CONV, run a cycle counter 0..CONV_CYC-1 and drive conv_strobe=1 exactly when the counter=0.
REQ-018 SHALL, at the edge ending counter=CONV_CYC-1, sample prod, add it zero-extended to acc, and decrement remaining.
REQ-019 SHALL saturate the sum: if acc+prod exceeds 2^ACC_W-1, acc becomes 2^ACC_W-1 and sat sets; sat is sticky until the next accepted start.
REQ-020 SHALL, when remaining reaches 0 at a sample edge, go to DONE; otherwise the counter wraps to 0 and CONV continues.
REQ-021 SHALL have latency such that, for len=N≥1, acc_valid rises N*CONV_CYC cycles after the start edge.
REQ-022 SHALL, in DONE, hold acc_valid=1 with acc and sat stable until acc_ready=1 at a clock edge; it SHALL then return to IDLE with acc_valid=0 on the next cycle, and acc/sat SHALL retain their values until the next start.
REQ-023 SHALL keep acc_ready ignored outside DONE.
REQ-024 SHALL produce no X on any output after reset, for any input sequence.

Reset
REQ-025 SHALL, on rst low (asynchronous, any state including mid-CONV), force IDLE and set acc=0, sat=0, acc_valid=0, busy=0, conv_strobe=0, and the counters to 0.
REQ-026 SHALL accept start on the first rising clk edge after rst deasserts.

Structure
REQ-027 SHALL place the FSM state encodings and the CONV_CYC and ACC_W defaults in the shared mac_pkg constants file.
REQ-028 SHALL implement the per-conversion cycle counter as one sub-module, conv_timer (enable, wrap pulse output); all remaining logic is inline.

Verification
REQ-029 SHALL verify basic frame: CONV_CYC=4, len=3, prod=10,20,30 at successive samples -> three conv_strobe pulses 4 cycles apart, acc_valid at cycle 12, acc=60, sat=0.
REQ-030 SHALL verify saturation: ACC_W=10, len=5, prod=255 constant -> acc=1023, sat=1, acc_valid at cycle 20.
REQ-031 SHALL verify backpressure: acc_ready held 0 for 7 cycles in DONE -> acc_valid and acc stable throughout; acc_ready=1 -> acc_valid=0 on the next cycle, busy=0.
REQ-032 SHALL verify len=0: start with len=0 -> DONE on the next cycle, acc=0, no conv_strobe pulses.
REQ-033 SHALL verify reset mid-frame: rst low during the second conversion of a len=4 frame -> all outputs 0 immediately; a new start after release runs a full frame.
REQ-034 SHALL verify start ignored: start pulsed during CONV and on the acceptance cycle -> no restart, len not relatched, exactly one frame result.
